dma_bus_arb: RTL and testbench
==============================

DMA_BUS_ARB -- requirements
Module: dma_bus_arb

Interface
REQ-001 Parameter MAX_TENURE, 8, maximum DMA cycles per bus tenure (legal 1..15).
REQ-002 Parameter HOLDOFF_CLKS, 2, minimum idle clocks after releasing the bus (legal 1..7).
REQ-003 CLK45  in  1  sole clock; all logic on the rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 DMAENA  in  1  DMA enabled.
REQ-006 DMADIR  in  1  1 = FIFO to memory (write), 0 = memory to FIFO (read).
REQ-007 FIFOFULL, FIFOEMPTY, FLUSHFIFO  in  1 each  FIFO status and flush request.
REQ-008 BGRANT_  in  1  CPU bus grant, active-low.
REQ-009 AS_, BGACKI_  in  1 each  bus address strobe and other-master BGACK, active-low.
REQ-010 CYCLEDONE  in  1  one-clock pulse from the CPU cycle state machine at the end of a cycle.
REQ-011 BREQ_  out  1  bus request, active-low.
REQ-012 BGACK_  out  1  bus grant acknowledge, active-low.
REQ-013 BUSOWN  out  1  DMA owns the bus.
REQ-014 STARTCYC  out  1  one-clock pulse that starts one CPU-bus DMA cycle.
REQ-015 ARBERR  out  1  sticky grant-timeout error.

Function
REQ-016 need = DMAENA & (DMADIR ? (~FIFOEMPTY & (FIFOFULL | FLUSHFIFO)) : ~FIFOFULL).
REQ-017 All outputs SHALL be registered.
REQ-018 The FSM SHALL use the states IDLE, REQ, WAITBUS, OWN, CYCLE, RELEASE and HOLDOFF.
REQ-019 IDLE: BREQ_=1 and BGACK_=1; the FSM SHALL go to REQ when need=1 and ARBERR=0.
REQ-020 REQ: BREQ_=0.
- BGRANT_=0 -> WAITBUS.
- need=0 before the grant -> IDLE, with BREQ_=1 on the next clock.
REQ-021 WAITBUS: BREQ_=0; the FSM SHALL go to OWN when AS_=1 and BGACKI_=1 in the same clock.
REQ-022 Entering OWN SHALL set BGACK_=0, BREQ_=1 and BUSOWN=1 together.
REQ-023 OWN: if need=1 and tenure count < MAX_TENURE, the FSM SHALL pulse STARTCYC for one clock and go to CYCLE; otherwise it SHALL go to RELEASE.
REQ-024 CYCLE: the FSM SHALL hold until CYCLEDONE=1, then increment the 4-bit tenure count (saturating at 15) and return to OWN.
REQ-025 DMAENA falling during CYCLE SHALL NOT abort the cycle; the FSM SHALL go to RELEASE after CYCLEDONE.
REQ-026 If CYCLEDONE and need-drop occur in the same clock, the FSM SHALL go OWN -> RELEASE with no further STARTCYC.
REQ-027 RELEASE: BGACK_=0 for exactly one clock, then BGACK_=1 and BUSOWN=0 on entry to HOLDOFF.
REQ-028 HOLDOFF: the FSM SHALL stay HOLDOFF_CLKS clocks with BREQ_=1, then go to IDLE.
REQ-029 The tenure count SHALL clear in IDLE.
REQ-030 BREQ_ and BGACK_ SHALL never both be 0 for more than the single transition clock into OWN.

Reset
REQ-031 RST=1 SHALL force state=IDLE, BREQ_=1, BGACK_=1, BUSOWN=0, STARTCYC=0, ARBERR=0 and count=0 at the next edge.
REQ-032 RST SHALL release the bus immediately, even mid-CYCLE, with no RELEASE or HOLDOFF sequence.

Configuration
REQ-033 Macro BUS_TIMEOUT_EN defined: an 8-bit counter SHALL run in REQ and WAITBUS and clear elsewhere.
- At 255 the FSM SHALL go to IDLE and set ARBERR=1.
- ARBERR SHALL hold until DMAENA=0 or RST.
REQ-034 Macro BUS_TIMEOUT_EN absent: ARBERR SHALL be tied to 0 and REQ/WAITBUS SHALL wait indefinitely.

Structure
REQ-035 The shared package sdmac_pkg SHALL hold the FSM state enum, the MAX_TENURE and HOLDOFF_CLKS defaults, and the TIMEOUT_CLKS=255 constant.
REQ-036 The timeout counter SHALL be the sub-module arb_timeout, instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-037 DMADIR=0, FIFOFULL=0, grant after 3 clocks, AS_=1 -> BREQ_ low 1 clock after need; BGACK_ low 1 clock after WAITBUS; 8 STARTCYC pulses; RELEASE; 2 HOLDOFF clocks; re-request.
REQ-038 DMADIR=1, FIFOEMPTY=0, FIFOFULL=0, FLUSHFIFO=0 -> no request; FLUSHFIFO=1 -> BREQ_=0 next clock.
REQ-039 Grant with AS_=0 for 5 clocks -> BGACK_ stays 1 until the clock after AS_=1.
REQ-040 DMAENA dropped mid-CYCLE, CYCLEDONE 4 clocks later -> no new STARTCYC; BGACK_=0 for 1 clock, then released.
REQ-041 RST pulsed in CYCLE -> all outputs at reset values next clock.
REQ-042 BUS_TIMEOUT_EN defined, BGRANT_=1 held -> ARBERR=1 and BREQ_=1 after 255 clocks; clears when DMAENA=0.

Source files
------------

// File: rtl/sdmac_pkg.sv
// Shared types and constants for the SDMAC bus arbiter.
// Holds the arbiter FSM state encoding, the default tenure/hold-off
// limits, the grant timeout length and the DMA "need bus" equation.
package sdmac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAITBUS,
      ST_OWN,
      ST_CYCLE,
      ST_RELEASE,
      ST_HOLDOFF
   } arb_state_t;

   localparam int DEF_MAX_TENURE   = 8;
   localparam int DEF_HOLDOFF_CLKS = 2;
   localparam int TIMEOUT_CLKS     = 255;

   // Writes need data in the FIFO and either a full FIFO or a flush;
   // reads need room in the FIFO.
   function automatic logic dma_need(input logic ena,
                                     input logic dir,
                                     input logic full,
                                     input logic empty,
                                     input logic flush);
      return ena & (dir ? (~empty & (full | flush)) : ~full);
   endfunction

endpackage

// File: rtl/arb_timeout.sv
// Grant timeout counter for the DMA bus arbiter.
// Counts clocks while run is high, clears as soon as run drops, and
// flags expiry once TIMEOUT_CLKS clocks have been spent waiting.
module arb_timeout
   import sdmac_pkg::*;
(
   input  logic clk,
   input  logic srst,
   input  logic run,
   output logic expired
);

   logic [7:0] cnt_reg;

   // Wait counter: saturates at the timeout value so it never wraps.
   always_ff @(posedge clk) begin
      if (srst || !run) begin
         cnt_reg <= 8'd0;
      end else if (cnt_reg != 8'(TIMEOUT_CLKS)) begin
         cnt_reg <= cnt_reg + 8'd1;
      end
   end

   assign expired = run & (cnt_reg == 8'(TIMEOUT_CLKS));

endmodule

// File: rtl/dma_bus_arb.sv
// DMA bus arbiter: requests the CPU bus when the FIFO needs service,
// runs up to MAX_TENURE DMA cycles per tenure, then releases the bus and
// waits HOLDOFF_CLKS idle clocks before it may request again.
// Optional feature: define BUS_TIMEOUT_EN to abandon a request that is
// not granted within TIMEOUT_CLKS clocks and raise the sticky ARBERR.
// All outputs are registered and computed from the next state, so the
// bus handshake signals change together on the state transition edge.
module dma_bus_arb
   import sdmac_pkg::*;
#(
   parameter int MAX_TENURE   = DEF_MAX_TENURE,
   parameter int HOLDOFF_CLKS = DEF_HOLDOFF_CLKS
)(
   input  logic CLK45,
   input  logic RST,
   input  logic DMAENA,
   input  logic DMADIR,
   input  logic FIFOFULL,
   input  logic FIFOEMPTY,
   input  logic FLUSHFIFO,
   input  logic BGRANT_,
   input  logic AS_,
   input  logic BGACKI_,
   input  logic CYCLEDONE,
   output logic BREQ_,
   output logic BGACK_,
   output logic BUSOWN,
   output logic STARTCYC,
   output logic ARBERR
);

   arb_state_t state_reg, state_next;
   logic [3:0] tenure_reg;
   logic [2:0] hold_reg;

   logic breq_n_reg,   breq_n_next;
   logic bgack_n_reg,  bgack_n_next;
   logic busown_reg,   busown_next;
   logic startcyc_reg, startcyc_next;
   logic arberr_reg,   arberr_next;

   logic need;
   logic timeout_hit;

   assign need = dma_need(DMAENA, DMADIR, FIFOFULL, FIFOEMPTY, FLUSHFIFO);

`ifdef BUS_TIMEOUT_EN
   logic run_timer;

   assign run_timer = (state_reg == ST_REQ) || (state_reg == ST_WAITBUS);

   arb_timeout u_timeout (
      .clk     (CLK45),
      .srst    (RST),
      .run     (run_timer),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // State register plus the tenure and hold-off counters it depends on.
   always_ff @(posedge CLK45) begin
      if (RST) begin
         state_reg  <= ST_IDLE;
         tenure_reg <= 4'd0;
         hold_reg   <= 3'd0;
      end else begin
         state_reg <= state_next;

         if (state_reg == ST_IDLE) begin
            tenure_reg <= 4'd0;
         end else if (state_reg == ST_CYCLE && CYCLEDONE && tenure_reg != 4'hF) begin
            tenure_reg <= tenure_reg + 4'd1;
         end

         if (state_reg == ST_HOLDOFF) begin
            hold_reg <= hold_reg + 3'd1;
         end else begin
            hold_reg <= 3'd0;
         end
      end
   end

   // Next-state logic for the request / own / release sequence.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (need && !arberr_reg) state_next = ST_REQ;
         end
         ST_REQ: begin
            if (timeout_hit)   state_next = ST_IDLE;
            else if (!BGRANT_) state_next = ST_WAITBUS;
            else if (!need)    state_next = ST_IDLE;
         end
         ST_WAITBUS: begin
            if (timeout_hit)          state_next = ST_IDLE;
            else if (AS_ && BGACKI_)  state_next = ST_OWN;
         end
         ST_OWN: begin
            // A cycle that ended together with a need drop lands here and
            // leaves without starting another cycle.
            if (need && tenure_reg < 4'(MAX_TENURE)) state_next = ST_CYCLE;
            else                                      state_next = ST_RELEASE;
         end
         ST_CYCLE: begin
            // A running cycle is never aborted; need is re-examined in OWN.
            if (CYCLEDONE) state_next = ST_OWN;
         end
         ST_RELEASE: begin
            state_next = ST_HOLDOFF;
         end
         ST_HOLDOFF: begin
            if (hold_reg == 3'(HOLDOFF_CLKS - 1)) state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so the registered outputs track it.
   always_comb begin
      breq_n_next   = !(state_next == ST_REQ || state_next == ST_WAITBUS);
      busown_next   = (state_next == ST_OWN) || (state_next == ST_CYCLE) ||
                      (state_next == ST_RELEASE);
      bgack_n_next  = !busown_next;
      startcyc_next = (state_reg == ST_OWN) && (state_next == ST_CYCLE);
`ifdef BUS_TIMEOUT_EN
      if (!DMAENA)          arberr_next = 1'b0;
      else if (timeout_hit) arberr_next = 1'b1;
      else                  arberr_next = arberr_reg;
`else
      arberr_next   = 1'b0;
`endif
   end

   // Output registers; reset drops the bus at once, even mid-cycle.
   always_ff @(posedge CLK45) begin
      if (RST) begin
         breq_n_reg   <= 1'b1;
         bgack_n_reg  <= 1'b1;
         busown_reg   <= 1'b0;
         startcyc_reg <= 1'b0;
         arberr_reg   <= 1'b0;
      end else begin
         breq_n_reg   <= breq_n_next;
         bgack_n_reg  <= bgack_n_next;
         busown_reg   <= busown_next;
         startcyc_reg <= startcyc_next;
         arberr_reg   <= arberr_next;
      end
   end

   assign BREQ_    = breq_n_reg;
   assign BGACK_   = bgack_n_reg;
   assign BUSOWN   = busown_reg;
   assign STARTCYC = startcyc_reg;
   assign ARBERR   = arberr_reg;

endmodule

// File: tb/tb_dma_bus_arb.sv
// Self-checking bench for dma_bus_arb (default parameters).
// A CPU-cycle responder answers each STARTCYC with CYCLEDONE after
// cpu_lat clocks; a monitor pops the expected STARTCYC count of every
// bus tenure from a scoreboard queue when BUSOWN falls.
// Build with BUS_TIMEOUT_EN defined to exercise the grant timeout.
module tb_dma_bus_arb;

   logic CLK45     = 1'b0;
   logic RST       = 1'b1;
   logic DMAENA    = 1'b0;
   logic DMADIR    = 1'b0;
   logic FIFOFULL  = 1'b0;
   logic FIFOEMPTY = 1'b0;
   logic FLUSHFIFO = 1'b0;
   logic BGRANT_   = 1'b1;
   logic AS_       = 1'b1;
   logic BGACKI_   = 1'b1;
   logic CYCLEDONE = 1'b0;
   logic BREQ_, BGACK_, BUSOWN, STARTCYC, ARBERR;

   int n_tests   = 0;
   int n_fail    = 0;
   int cpu_lat   = 2;
   bit mon_en    = 1'b0;
   int pulse_cnt = 0;
   int exp_q[$];

   always #5 CLK45 = ~CLK45;

   dma_bus_arb dut (
      .CLK45     (CLK45),
      .RST       (RST),
      .DMAENA    (DMAENA),
      .DMADIR    (DMADIR),
      .FIFOFULL  (FIFOFULL),
      .FIFOEMPTY (FIFOEMPTY),
      .FLUSHFIFO (FLUSHFIFO),
      .BGRANT_   (BGRANT_),
      .AS_       (AS_),
      .BGACKI_   (BGACKI_),
      .CYCLEDONE (CYCLEDONE),
      .BREQ_     (BREQ_),
      .BGACK_    (BGACK_),
      .BUSOWN    (BUSOWN),
      .STARTCYC  (STARTCYC),
      .ARBERR    (ARBERR)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK45);
         #1;
      end
   endtask

   task automatic wait_startcyc(input string tag);
      for (int i = 0; i < 10 && STARTCYC !== 1'b1; i++) step(1);
      check(tag, 32'(STARTCYC), 1);
   endtask

   task automatic wait_release(input int max, output int n_own);
      n_own = 1;
      for (int i = 0; i < max; i++) begin
         step(1);
         if (BUSOWN !== 1'b1) break;
         n_own++;
      end
      check("release_seen", 32'(BUSOWN), 0);
   endtask

   // CPU cycle state machine stand-in.
   initial begin
      forever begin
         @(posedge CLK45);
         #1;
         if (STARTCYC === 1'b1) begin
            repeat (cpu_lat) begin
               @(posedge CLK45);
               #1;
            end
            CYCLEDONE = 1'b1;
            @(posedge CLK45);
            #1;
            CYCLEDONE = 1'b0;
         end
      end
   end

   // Tenure monitor: STARTCYC count per tenure and handshake overlap.
   initial begin
      logic prev_own;
      int   exp_v;
      prev_own = 1'b0;
      forever begin
         @(posedge CLK45);
         #1;
         if (mon_en) begin
            check("breq_bgack_overlap", 32'((BREQ_ === 1'b0) && (BGACK_ === 1'b0)), 0);
            if (STARTCYC === 1'b1) pulse_cnt++;
            if (prev_own && BUSOWN !== 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("tenure_unexpected", 1, 0);
               end else begin
                  exp_v = exp_q.pop_front();
                  $display("[TB] tenure ended: %0d STARTCYC pulses (expected %0d)", pulse_cnt, exp_v);
                  check("tenure_pulses", pulse_cnt, exp_v);
               end
               pulse_cnt = 0;
            end
            prev_own = (BUSOWN === 1'b1);
         end
      end
   end

   initial begin
      int n_own;
      int low;
      int sc;

      // Reset values
      step(2);
      check("rst_breq",     32'(BREQ_),    1);
      check("rst_bgack",    32'(BGACK_),   1);
      check("rst_busown",   32'(BUSOWN),   0);
      check("rst_startcyc", 32'(STARTCYC), 0);
      check("rst_arberr",   32'(ARBERR),   0);
      RST    = 1'b0;
      mon_en = 1'b1;
      step(1);

      // Read tenure: grant after 3 clocks, 8 cycles, release, hold-off, re-request
      $display("[TB] read tenure with delayed grant");
      cpu_lat = 2;
      DMAENA  = 1'b1;
      step(1);
      check("s1_breq_after_need", 32'(BREQ_),  0);
      check("s1_bgack_idle",      32'(BGACK_), 1);
      step(2);
      check("s1_breq_held", 32'(BREQ_), 0);
      BGRANT_ = 1'b0;
      step(1);
      check("s1_waitbus_breq",  32'(BREQ_),  0);
      check("s1_waitbus_bgack", 32'(BGACK_), 1);
      step(1);
      check("s1_own_bgack",  32'(BGACK_), 0);
      check("s1_own_breq",   32'(BREQ_),  1);
      check("s1_own_busown", 32'(BUSOWN), 1);
      BGRANT_ = 1'b1;
      exp_q.push_back(8);
      wait_release(200, n_own);
      check("s1_own_clocks",      n_own,          34);
      check("s1_bgack_released",  32'(BGACK_),    1);
      step(1);
      check("s1_holdoff_breq", 32'(BREQ_), 1);
      step(1);
      check("s1_idle_breq", 32'(BREQ_), 1);
      step(1);
      check("s1_rerequest", 32'(BREQ_), 0);
      DMAENA = 1'b0;
      step(1);
      check("s1_need_drop_breq", 32'(BREQ_), 1);
      step(1);

      // Write direction: request only on flush
      $display("[TB] write direction flush request");
      DMADIR    = 1'b1;
      FIFOEMPTY = 1'b0;
      FIFOFULL  = 1'b0;
      FLUSHFIFO = 1'b0;
      DMAENA    = 1'b1;
      step(3);
      check("s2_no_req", 32'(BREQ_), 1);
      FLUSHFIFO = 1'b1;
      step(1);
      check("s2_flush_req", 32'(BREQ_), 0);
      FLUSHFIFO = 1'b0;
      step(1);
      check("s2_withdraw", 32'(BREQ_), 1);
      DMAENA = 1'b0;
      DMADIR = 1'b0;
      step(1);

      // Grant while another master holds AS_
      $display("[TB] grant with bus busy");
      BGRANT_ = 1'b0;
      AS_     = 1'b0;
      DMAENA  = 1'b1;
      step(2);
      check("s3_waitbus_breq", 32'(BREQ_), 0);
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("s3_as_busy_bgack", 32'(BGACK_), 1);
      end
      AS_     = 1'b1;
      BGACKI_ = 1'b0;
      step(1);
      check("s3_bgacki_busy_bgack", 32'(BGACK_), 1);
      BGACKI_ = 1'b1;
      step(1);
      check("s3_own_bgack", 32'(BGACK_), 0);
      BGRANT_ = 1'b1;
      exp_q.push_back(8);
      wait_release(200, n_own);
      check("s3_own_clocks", n_own, 34);
      DMAENA = 1'b0;
      step(4);

      // DMAENA dropped mid-cycle
      $display("[TB] enable dropped during cycle");
      cpu_lat = 4;
      BGRANT_ = 1'b0;
      DMAENA  = 1'b1;
      step(3);
      check("s4_own", 32'(BUSOWN), 1);
      BGRANT_ = 1'b1;
      exp_q.push_back(1);
      wait_startcyc("s4_startcyc");
      DMAENA = 1'b0;
      low = 0;
      sc  = 0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (BGACK_ === 1'b0) low++;
         if (STARTCYC === 1'b1) sc++;
      end
      check("s4_bgack_low_clocks", low, 6);
      check("s4_no_startcyc",      sc,  0);
      step(1);
      check("s4_bgack_released",  32'(BGACK_), 1);
      check("s4_busown_released", 32'(BUSOWN), 0);
      step(3);

      // Reset during a cycle
      $display("[TB] reset during cycle");
      cpu_lat = 6;
      BGRANT_ = 1'b0;
      DMAENA  = 1'b1;
      step(3);
      check("s5_own", 32'(BUSOWN), 1);
      BGRANT_ = 1'b1;
      exp_q.push_back(1);
      wait_startcyc("s5_startcyc");
      RST = 1'b1;
      step(1);
      check("s5_rst_breq",     32'(BREQ_),    1);
      check("s5_rst_bgack",    32'(BGACK_),   1);
      check("s5_rst_busown",   32'(BUSOWN),   0);
      check("s5_rst_startcyc", 32'(STARTCYC), 0);
      check("s5_rst_arberr",   32'(ARBERR),   0);
      RST    = 1'b0;
      DMAENA = 1'b0;
      step(8);
      check("s5_idle_after", 32'(BREQ_), 1);

      // Grant never arrives
`ifdef BUS_TIMEOUT_EN
      $display("[TB] grant timeout");
      BGRANT_ = 1'b1;
      DMAENA  = 1'b1;
      low     = 0;
      for (int i = 0; i < 300 && ARBERR !== 1'b1; i++) begin
         step(1);
         if (BREQ_ === 1'b0) low++;
      end
      check("s6_arberr_set",      32'(ARBERR), 1);
      check("s6_breq_released",   32'(BREQ_),  1);
      check("s6_req_clocks_range", 32'(low >= 255 && low <= 256), 1);
      step(3);
      check("s6_no_rerequest", 32'(BREQ_),  1);
      check("s6_arberr_held",  32'(ARBERR), 1);
      DMAENA = 1'b0;
      step(1);
      check("s6_arberr_cleared", 32'(ARBERR), 0);
`else
      $display("[TB] no grant, timeout disabled");
      BGRANT_ = 1'b1;
      DMAENA  = 1'b1;
      step(300);
      check("s6_arberr_tied",       32'(ARBERR), 0);
      check("s6_still_requesting",  32'(BREQ_),  0);
      DMAENA = 1'b0;
      step(1);
`endif
      step(2);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
